// File: rtl/sata_link_seq_if.sv
// sata_link_seq_if: bundles the host/PHY-facing signals of the SATA link
// bring-up sequencer.
//   slave  : sequencer side (inputs plllkdet/port_en/linkup/err_clr,
//            outputs resets, StartComm, grant, status).
//   master : the surrounding host controllers / PHY wrapper.
interface sata_link_seq_if;
  logic       plllkdet;     // GTX PLL lock, asynchronous
  logic [1:0] port_en;      // per-port host enable, level
  logic [1:0] linkup;       // per-port PHY link-up, clk domain
  logic [1:0] err_clr;      // per-port clear of timeout_err / retry_cnt
  logic       gtxreset;     // shared tile reset
  logic [1:0] phyreset;     // per-port PHY reset
  logic [1:0] startcomm;    // per-port one-cycle StartComm
  logic [1:0] grant;        // OOB window owner, one-hot or zero
  logic [1:0] link_ready;   // port is up
  logic [1:0] timeout_err;  // sticky link timeout
  logic [7:0] retry_cnt0;   // saturating retry count, port 0
  logic [7:0] retry_cnt1;   // saturating retry count, port 1

  modport slave (
    input  plllkdet, port_en, linkup, err_clr,
    output gtxreset, phyreset, startcomm, grant, link_ready, timeout_err,
           retry_cnt0, retry_cnt1
  );

  modport master (
    output plllkdet, port_en, linkup, err_clr,
    input  gtxreset, phyreset, startcomm, grant, link_ready, timeout_err,
           retry_cnt0, retry_cnt1
  );
endinterface

// File: rtl/sata_link_seq.sv
// sata_link_seq: bring-up sequencer and OOB arbiter for the dual-port SATA
// GTX PHY. Holds the tile in reset, waits for PLL lock, then lets each port
// run reset -> StartComm -> link-up wait with timeout, backoff and retry.
// A round-robin arbiter gives at most one port the OOB/reset window.
// Ports:
//   clk   : PHY user clock
//   rst_n : asynchronous active-low reset
//   bus   : sata_link_seq_if.slave (see interface for signal list)

// Per-port bring-up FSM. All outputs registered from the next state.
//   i_run/i_drop : global FSM in run / lock just lost (force idle)
//   i_win        : arbiter grants this port this cycle
//   o_req        : port is requesting the window
//   o_hold       : port will own the window next cycle (drives grant reg)
module sata_link_port #(
  parameter int C_PHY_RST_CYCLES = 8,
  parameter int C_LINK_TIMEOUT   = 1000000,
  parameter int C_BACKOFF        = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_run,
  input  logic       i_drop,
  input  logic       i_linkup,
  input  logic       i_err_clr,
  input  logic       i_win,
  output logic       o_req,
  output logic       o_hold,
  output logic       o_phyreset,
  output logic       o_startcomm,
  output logic       o_link_ready,
  output logic       o_timeout_err,
  output logic [7:0] o_retry_cnt
);
  typedef enum logic [2:0] {
    P_IDLE, P_REQ, P_RST, P_COMM, P_WAIT, P_UP, P_BACKOFF
  } p_state_t;

  localparam logic [23:0] L_RST = 24'(C_PHY_RST_CYCLES - 1);
  localparam logic [23:0] L_LTO = 24'(C_LINK_TIMEOUT - 1);
  localparam logic [23:0] L_BO  = 24'(C_BACKOFF - 1);

  p_state_t    r_state, w_nxt;
  logic [23:0] r_cnt;
  logic        w_to, w_inc;
  logic        r_phyreset, r_startcomm, r_link_ready, r_timeout_err;
  logic [7:0]  r_retry, w_retry_base;

  always_comb begin
    w_nxt = r_state;
    w_to  = 1'b0;
    w_inc = 1'b0;
    if (i_drop || !i_en) w_nxt = P_IDLE;
    else begin
      case (r_state)
        P_IDLE:    if (i_run) w_nxt = P_REQ;
        P_REQ:     if (i_win) w_nxt = P_RST;
        P_RST:     if (r_cnt == L_RST) w_nxt = P_COMM;
        P_COMM:    w_nxt = P_WAIT;
        P_WAIT: begin
          if (i_linkup) w_nxt = P_UP;
          else if (r_cnt == L_LTO) begin
            w_nxt = P_BACKOFF;
            w_to  = 1'b1;
            w_inc = 1'b1;
          end
        end
        P_UP: begin
          if (!i_linkup) begin
            w_nxt = P_BACKOFF;
            w_inc = 1'b1;
          end
        end
        P_BACKOFF: if (r_cnt == L_BO) w_nxt = P_REQ;
        default:   w_nxt = P_IDLE;
      endcase
    end
  end

  // A clear in the same cycle as an increment restarts the count from zero.
  assign w_retry_base = i_err_clr ? 8'd0 : r_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= P_IDLE;
      r_cnt         <= '0;
      r_phyreset    <= 1'b1;
      r_startcomm   <= 1'b0;
      r_link_ready  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_retry       <= '0;
    end else begin
      r_state      <= w_nxt;
      r_cnt        <= (w_nxt != r_state) ? 24'd0 : r_cnt + 24'd1;
      r_phyreset   <= (w_nxt inside {P_IDLE, P_REQ, P_RST, P_BACKOFF});
      r_startcomm  <= (w_nxt == P_COMM);
      r_link_ready <= (w_nxt == P_UP);
      if (w_to)           r_timeout_err <= 1'b1;
      else if (i_err_clr) r_timeout_err <= 1'b0;
      if (w_inc) r_retry <= (w_retry_base == 8'hFF) ? 8'hFF : w_retry_base + 8'd1;
      else       r_retry <= w_retry_base;
    end
  end

  assign o_req         = (r_state == P_REQ) && i_en && !i_drop;
  assign o_hold        = (w_nxt inside {P_RST, P_COMM, P_WAIT});
  assign o_phyreset    = r_phyreset;
  assign o_startcomm   = r_startcomm;
  assign o_link_ready  = r_link_ready;
  assign o_timeout_err = r_timeout_err;
  assign o_retry_cnt   = r_retry;
endmodule

module sata_link_seq #(
  parameter int C_GTX_RST_CYCLES = 16,
  parameter int C_PLL_TIMEOUT    = 65535,
  parameter int C_PHY_RST_CYCLES = 8,
  parameter int C_LINK_TIMEOUT   = 1000000,
  parameter int C_BACKOFF        = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  sata_link_seq_if.slave bus
);
  localparam int NUM_PORTS = 2;
  localparam logic [23:0] L_GTX = 24'(C_GTX_RST_CYCLES - 1);
  localparam logic [23:0] L_PLL = 24'(C_PLL_TIMEOUT - 1);

  typedef enum logic [1:0] {G_RST, G_PLL, G_RUN} g_state_t;

  g_state_t    r_g_state;
  logic [23:0] r_g_cnt;
  logic        r_gtxreset;
  logic        r_lock_meta, r_lock;
  logic        w_run, w_drop;

  logic [NUM_PORTS-1:0]      w_req, w_hold, w_win, r_grant;
  logic                      r_last;  // index of the port granted most recently
  logic [NUM_PORTS-1:0][7:0] w_retry;

  assign w_run  = (r_g_state == G_RUN);
  assign w_drop = w_run && !r_lock;

  // Global tile FSM with plllkdet synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock      <= 1'b0;
      r_g_state   <= G_RST;
      r_g_cnt     <= '0;
      r_gtxreset  <= 1'b1;
    end else begin
      r_lock_meta <= bus.plllkdet;
      r_lock      <= r_lock_meta;
      case (r_g_state)
        G_RST: begin
          if (r_g_cnt == L_GTX) begin
            r_g_state  <= G_PLL;
            r_g_cnt    <= '0;
            r_gtxreset <= 1'b0;
          end else r_g_cnt <= r_g_cnt + 24'd1;
        end
        G_PLL: begin
          if (r_lock) begin
            r_g_state <= G_RUN;
            r_g_cnt   <= '0;
          end else if (r_g_cnt == L_PLL) begin
            r_g_state  <= G_RST;
            r_g_cnt    <= '0;
            r_gtxreset <= 1'b1;
          end else r_g_cnt <= r_g_cnt + 24'd1;
        end
        G_RUN: begin
          if (!r_lock) begin
            r_g_state  <= G_RST;
            r_g_cnt    <= '0;
            r_gtxreset <= 1'b1;
          end
        end
        default: begin
          r_g_state  <= G_RST;
          r_g_cnt    <= '0;
          r_gtxreset <= 1'b1;
        end
      endcase
    end
  end

  // Arbitrate only while the window is free; on a tie the port that did
  // not win last time goes first. The grant register then simply follows
  // each port's "owns window next cycle" flag, so release is immediate and
  // a new grant can only land one cycle later.
  always_comb begin
    w_win = '0;
    if (r_grant == '0) begin
      if (&w_req) w_win = r_last ? 2'b01 : 2'b10;
      else        w_win = w_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_last  <= 1'b1;
    end else begin
      r_grant <= w_hold;
      if (|w_win) r_last <= w_win[1];
    end
  end

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    sata_link_port #(
      .C_PHY_RST_CYCLES (C_PHY_RST_CYCLES),
      .C_LINK_TIMEOUT   (C_LINK_TIMEOUT),
      .C_BACKOFF        (C_BACKOFF)
    ) u_port (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_en          (bus.port_en[n]),
      .i_run         (w_run),
      .i_drop        (w_drop),
      .i_linkup      (bus.linkup[n]),
      .i_err_clr     (bus.err_clr[n]),
      .i_win         (w_win[n]),
      .o_req         (w_req[n]),
      .o_hold        (w_hold[n]),
      .o_phyreset    (bus.phyreset[n]),
      .o_startcomm   (bus.startcomm[n]),
      .o_link_ready  (bus.link_ready[n]),
      .o_timeout_err (bus.timeout_err[n]),
      .o_retry_cnt   (w_retry[n])
    );
  end

  assign bus.gtxreset   = r_gtxreset;
  assign bus.grant      = r_grant;
  assign bus.retry_cnt0 = w_retry[0];
  assign bus.retry_cnt1 = w_retry[1];
endmodule

// File: tb/tb_sata_link_seq.sv
`timescale 1ns/1ps
module tb_sata_link_seq;
  localparam int GTX   = 16;
  localparam int PLLTO = 200;
  localparam int PRST  = 8;
  localparam int LTO   = 100;
  localparam int BO    = 32;
  localparam int NRET  = 300;
  // StartComm to StartComm when every attempt times out:
  // WAIT LTO + BACKOFF BO + one REQ cycle + PRST reset + the COMM cycle.
  localparam int PERIOD = LTO + BO + 1 + PRST + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   overlap = 0;

  typedef struct {
    int cyc;    // expected cycle of the pulse, -1 = any
    int retry;
    int err;
  } sc_t;
  sc_t q0[$];
  sc_t q1[$];

  sata_link_seq_if bus();

  sata_link_seq #(
    .C_GTX_RST_CYCLES (GTX),
    .C_PLL_TIMEOUT    (PLLTO),
    .C_PHY_RST_CYCLES (PRST),
    .C_LINK_TIMEOUT   (LTO),
    .C_BACKOFF        (BO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_sc(input int n, input sc_t e);
    if (e.cyc >= 0) check($sformatf("sc%0d_cycle", n), cyc, e.cyc);
    check($sformatf("sc%0d_retry", n),
          (n == 1) ? int'(bus.retry_cnt1) : int'(bus.retry_cnt0), e.retry);
    check($sformatf("sc%0d_err", n), int'(bus.timeout_err[n]), e.err);
  endtask

  // Monitor: every StartComm pulse consumes one expectation for its port.
  always @(negedge clk) begin
    sc_t e;
    if (rst_n) begin
      if (bus.grant == 2'b11) overlap++;
      if (bus.startcomm[0]) begin
        if (q0.size() == 0) check("sc0_unexpected", 1, 0);
        else begin e = q0.pop_front(); cmp_sc(0, e); end
      end
      if (bus.startcomm[1]) begin
        if (q1.size() == 0) check("sc1_unexpected", 1, 0);
        else begin e = q1.pop_front(); cmp_sc(1, e); end
      end
    end
  end

  // Cycle c: 1ns after the posedge that starts it.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    go(c);
    @(negedge clk);
  endtask

  task automatic wait_sc(input int n, output int t);
    t = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.startcomm[n]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check($sformatf("wait_sc%0d_timeout", n), 0, 1);
  endtask

  function automatic sc_t mk(input int c, input int r, input int e);
    sc_t s;
    s.cyc = c; s.retry = r; s.err = e;
    return s;
  endfunction

  initial begin
    int t0, te, s, s0, s1, d, p, l0, l1, sl;
    bus.plllkdet = 1'b0;
    bus.port_en  = 2'b00;
    bus.linkup   = 2'b00;
    bus.err_clr  = 2'b00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gtxreset", int'(bus.gtxreset), 1);
    check("rst_phyreset", int'(bus.phyreset), 3);
    check("rst_startcomm", int'(bus.startcomm), 0);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_link_ready", int'(bus.link_ready), 0);
    check("rst_timeout_err", int'(bus.timeout_err), 0);
    check("rst_retry0", int'(bus.retry_cnt0), 0);
    check("rst_retry1", int'(bus.retry_cnt1), 0);

    // Bring-up: tile reset window, PLL lock, port 0 trains
    @(posedge clk); #1;
    rst_n = 1'b1;
    t0 = cyc;
    at_neg(t0 + GTX - 1); check("gtx_high_last", int'(bus.gtxreset), 1);
    at_neg(t0 + GTX);     check("gtx_low_first", int'(bus.gtxreset), 0);
    go(t0 + 40); bus.plllkdet = 1'b1;
    te = t0 + 60 + int'($urandom_range(0, 20));
    go(te);
    check("locked_gtx", int'(bus.gtxreset), 0);
    bus.port_en = 2'b01;
    s = te + 2 + PRST;
    q0.push_back(mk(s, 0, 0));
    at_neg(te + 2);        check("bu_grant", int'(bus.grant), 1);
                           check("bu_phyrst_on", int'(bus.phyreset[0]), 1);
    at_neg(te + 1 + PRST); check("bu_phyrst_last", int'(bus.phyreset[0]), 1);
    at_neg(s);             check("bu_phyrst_off", int'(bus.phyreset[0]), 0);
    go(s + 50); bus.linkup[0] = 1'b1;
    at_neg(s + 51);
    check("bu_link_ready", int'(bus.link_ready), 1);
    check("bu_grant_rel", int'(bus.grant), 0);

    // Link drop in P_UP: retry, no timeout flag, backoff, re-request
    d = s + 51 + int'($urandom_range(5, 30));
    go(d); bus.linkup[0] = 1'b0;
    s = d + BO + PRST + 2;
    q0.push_back(mk(s, 1, 0));
    at_neg(d + 1);
    check("drop_retry0", int'(bus.retry_cnt0), 1);
    check("drop_err0", int'(bus.timeout_err[0]), 0);
    check("drop_ready", int'(bus.link_ready[0]), 0);
    check("drop_phyrst", int'(bus.phyreset[0]), 1);

    // Async reset mid-P_WAIT
    go(s + int'($urandom_range(3, 40)));
    #2 rst_n = 1'b0;
    #1;
    check("arst_gtxreset", int'(bus.gtxreset), 1);
    check("arst_phyreset", int'(bus.phyreset), 3);
    check("arst_grant", int'(bus.grant), 0);
    check("arst_ready", int'(bus.link_ready), 0);
    check("arst_retry0", int'(bus.retry_cnt0), 0);
    bus.port_en = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    t0 = cyc;
    at_neg(t0 + GTX - 1); check("arst_gtx_high", int'(bus.gtxreset), 1);
    at_neg(t0 + GTX);     check("arst_gtx_low", int'(bus.gtxreset), 0);

    // Contention: both ports enabled together, port 0 wins after reset
    te = t0 + 60;
    l0 = int'($urandom_range(3, 40));
    l1 = int'($urandom_range(3, 40));
    s0 = te + 2 + PRST;
    s1 = s0 + l0 + 2 + PRST;
    q0.push_back(mk(s0, 0, 0));
    q1.push_back(mk(s1, 0, 0));
    go(te); bus.port_en = 2'b11;
    at_neg(te + 2); check("ct_grant0", int'(bus.grant), 1);
    go(s0 + l0); bus.linkup[0] = 1'b1;
    at_neg(s0 + l0 + 1); check("ct_gap", int'(bus.grant), 0);
    at_neg(s0 + l0 + 2); check("ct_grant1", int'(bus.grant), 2);
    go(s1 + l1); bus.linkup[1] = 1'b1;
    at_neg(s1 + l1 + 1);
    check("ct_ready", int'(bus.link_ready), 3);
    check("ct_grant_rel", int'(bus.grant), 0);

    // PLL loss: tile reset, both ports forced idle, then re-train
    p = s1 + l1 + 10 + int'($urandom_range(0, 10));
    go(p); bus.plllkdet = 1'b0;
    at_neg(p + 5);
    check("pll_gtx", int'(bus.gtxreset), 1);
    check("pll_ready", int'(bus.link_ready), 0);
    check("pll_phyrst", int'(bus.phyreset), 3);
    check("pll_grant", int'(bus.grant), 0);
    check("pll_retry0", int'(bus.retry_cnt0), 0);
    check("pll_retry1", int'(bus.retry_cnt1), 0);
    go(p + 6); bus.linkup = 2'b00;
    q0.push_back(mk(-1, 0, 0));
    go(p + 30); bus.plllkdet = 1'b1;
    wait_sc(0, s0);
    s1 = s0 + 5 + 2 + PRST;
    q1.push_back(mk(s1, 0, 0));
    go(s0 + 5); bus.linkup[0] = 1'b1;

    // Disable port 1 in P_WAIT
    go(s1 + 5); bus.port_en[1] = 1'b0;
    at_neg(s1 + 6);
    check("dis_grant", int'(bus.grant), 0);
    check("dis_phyrst1", int'(bus.phyreset[1]), 1);
    check("dis_ready0", int'(bus.link_ready[0]), 1);

    // Repeated timeout on port 1, retry saturation, err_clr
    te = s1 + 20;
    s = te + 2 + PRST;
    for (int k = 0; k <= NRET; k++)
      q1.push_back(mk(s + k * PERIOD, (k > 255) ? 255 : k, (k > 0) ? 1 : 0));
    go(te); bus.port_en[1] = 1'b1;
    sl = s + NRET * PERIOD;
    at_neg(sl + LTO - 1);
    check("sat_retry1", int'(bus.retry_cnt1), 255);
    go(sl + LTO); bus.err_clr[1] = 1'b1;   // same cycle as the timeout
    go(sl + LTO + 1); bus.err_clr[1] = 1'b0;
    @(negedge clk);
    check("clr_vs_to_retry", int'(bus.retry_cnt1), 1);
    check("clr_vs_to_err", int'(bus.timeout_err[1]), 1);
    go(sl + LTO + 10); bus.err_clr[1] = 1'b1;
    go(sl + LTO + 11); bus.err_clr[1] = 1'b0;
    @(negedge clk);
    check("clr_retry1", int'(bus.retry_cnt1), 0);
    check("clr_err1", int'(bus.timeout_err[1]), 0);
    check("clr_ready0", int'(bus.link_ready[0]), 1);
    go(sl + LTO + 12); bus.port_en[1] = 1'b0;

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("grant_overlap_cycles", overlap, 0);
    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
